tx_pingpong_ctrl: RTL
=====================

# tx_pingpong_ctrl

Ping-pong scheduler for the 512x16 TX buffer between the packet decoder (writer) and the USB slave FIFO IN path (reader). Splits the buffer into two banks selected by the address MSB, grants a free bank to the writer, queues completed banks for the reader in order, and starts/retires USB IN packets. Sits on the inverted-IFCLK (`mclk`) domain between `pkt_decode` and `usb_slavefifo`, replacing the direct `tx_eop` to `tx_cache_sop` wiring.

## Interface
- `ADDR_NBIT`, 8, per-bank word address width; bank depth = 2^ADDR_NBIT words.
- `TMO_NBIT`, 16, drain watchdog counter width.

- `clk`  in  1  buffer/FIFO clock (`mclk`, 48 MHz).
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_req`  in  1  writer requests a bank; held high until `wr_gnt`.
- `wr_gnt`  out  1  one-cycle grant pulse.
- `wr_bank`  out  1  bank index for writer (buffer write address MSB); valid from `wr_gnt` to `wr_eop`.
- `wr_eop`  in  1  one-cycle pulse, writer finished the granted bank.
- `wr_len`  in  ADDR_NBIT+1  word count written, sampled with `wr_eop`; 0..2^ADDR_NBIT.
- `rd_sop`  out  1  one-cycle pulse, start USB IN packet.
- `rd_bank`  out  1  bank to drain (buffer read address MSB); stable from `rd_sop` to retire.
- `rd_len`  out  ADDR_NBIT+1  word count of packet, stable with `rd_bank`.
- `rd_done`  in  1  one-cycle pulse, slave FIFO finished packet (PKEND issued).
- `bank_rdy`  out  2  per-bank READY-or-DRAINING flags.
- `busy`  out  1  any bank not FREE.
- `err`  out  1  sticky protocol/timeout error; cleared only by reset.

## Operation
- Per-bank state: FREE, FILLING, READY, DRAINING; per-bank length register ADDR_NBIT+1 bits.
- Pointers: `wp` (next bank to grant), `rp` (next bank to drain), both reset to 0, toggle on use; strict in-order.
- Grant: `wr_req` high, no bank FILLING, bank[`wp`] FREE -> `wr_gnt`, `wr_bank`=`wp`, bank[`wp`] -> FILLING, `wp` toggles. Otherwise writer waits.
- Fill done: `wr_eop` with bank FILLING -> capture `wr_len`; len>0 -> READY; len=0 -> FREE (no USB packet). `wr_len` > 2^ADDR_NBIT -> clamp to 2^ADDR_NBIT, set `err`.
- `wr_eop` with no bank FILLING: ignored, set `err`.
- Drain: reader idle and bank[`rp`] READY -> `rd_sop`, `rd_bank`=`rp`, `rd_len`=len, bank -> DRAINING.
- Retire: `rd_done` while DRAINING -> bank FREE, `rp` toggles, reader idle. `rd_done` while idle: ignored, set `err`.
- Simultaneous events: grant, fill-done and retire in one cycle are all honoured; a bank retired this cycle is grantable next cycle (no same-cycle bypass).
- Both banks READY/DRAINING: writer stalls (no `wr_gnt`) until a retire.

## Timing
- Reset values: `wr_gnt`=0, `wr_bank`=0, `rd_sop`=0, `rd_bank`=0, `rd_len`=0, `bank_rdy`=2'b00, `busy`=0, `err`=0; all banks FREE; watchdog 0.
- All outputs registered.
- `wr_req` sampled at edge N -> `wr_gnt` high cycle N+1 (bank available).
- `wr_eop` at N -> bank READY at N+1 -> `rd_sop` at N+2 if reader idle (2-cycle fill-to-start latency).
- `rd_done` at N -> bank FREE at N+1; queued READY bank -> `rd_sop` at N+2.
- `wr_req` must drop the cycle after `wr_gnt`; a still-high `wr_req` is a new request.
- Reset mid-operation: all state discarded immediately; in-flight packet contents lost, no `rd_sop` replay.

## Configuration
- `TX_WATCHDOG_EN` defined: watchdog counts cycles in DRAINING; reaching 2^TMO_NBIT-1 without `rd_done` forces bank FREE, toggles `rp`, sets `err`; counter clears on every `rd_sop`.
- Undefined: no counter; DRAINING waits for `rd_done` indefinitely; `TMO_NBIT` unused.

## Test plan
- Reset, `wr_req` 1 cycle -> `wr_gnt` next cycle, `wr_bank`=0; `wr_eop` `wr_len`=100 -> `rd_sop` 2 cycles later, `rd_bank`=0, `rd_len`=100; `rd_done` -> `busy`=0.
- Four back-to-back packets (len 256, 1, 37, 256) with `rd_done` delayed 500 cycles -> grants alternate banks 0,1,0,1; third `wr_gnt` withheld until first `rd_done`; `rd_sop` order/lengths match.
- `wr_eop` with `wr_len`=0 -> no `rd_sop`, bank FREE next cycle, `err`=0.
- `rd_done` with reader idle, and `wr_eop` with no grant -> no state change, `err`=1 sticky.
- Same-cycle `wr_eop` (bank 1) and `rd_done` (bank 0) -> bank 0 FREE, `rd_sop` bank 1 two cycles later.
- With `TX_WATCHDOG_EN`, `TMO_NBIT`=4, no `rd_done` -> bank freed after 15 DRAINING cycles, `err`=1; without macro bank stays DRAINING past 1000 cycles.

Source files
------------

// File: rtl/tx_pingpong_ctrl.sv
// Two-bank ping-pong scheduler between the packet writer and the USB IN reader.
// Optional drain watchdog: define TX_WATCHDOG_EN.
module tx_pingpong_ctrl #(
  parameter int ADDR_NBIT = 8,
  parameter int TMO_NBIT  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_req,
  output logic                 wr_gnt,
  output logic                 wr_bank,
  input  logic                 wr_eop,
  input  logic [ADDR_NBIT:0]   wr_len,
  output logic                 rd_sop,
  output logic                 rd_bank,
  output logic [ADDR_NBIT:0]   rd_len,
  input  logic                 rd_done,
  output logic [1:0]           bank_rdy,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {ST_FREE, ST_FILLING, ST_READY, ST_DRAINING} bank_st_e;

  localparam logic [ADDR_NBIT:0] MAX_LEN = {1'b1, {ADDR_NBIT{1'b0}}};

  bank_st_e           st_q [2];
  bank_st_e           st_d [2];
  logic [ADDR_NBIT:0] len_q [2];
  logic               wp_q, rp_q, wp_d, rp_d;
  logic               wr_gnt_q, wr_bank_q, rd_sop_q, rd_bank_q, busy_q, err_q;
  logic [ADDR_NBIT:0] rd_len_q;
  logic [1:0]         bank_rdy_q, bank_rdy_d, busy_d;

  logic               filling_any, fill_bank, draining_any, len_over, fill_empty;
  logic [ADDR_NBIT:0] len_clamp;
  logic               do_grant, do_fill, do_drain, do_retire, do_tmo, err_set;

  assign filling_any  = (st_q[0] == ST_FILLING) || (st_q[1] == ST_FILLING);
  assign fill_bank    = (st_q[1] == ST_FILLING);
  assign draining_any = (st_q[0] == ST_DRAINING) || (st_q[1] == ST_DRAINING);
  assign len_over     = (wr_len > MAX_LEN);
  assign len_clamp    = len_over ? MAX_LEN : wr_len;
  assign fill_empty   = (len_clamp == '0);

  assign do_grant  = wr_req && !filling_any && (st_q[wp_q] == ST_FREE);
  assign do_fill   = wr_eop && filling_any;
  assign do_drain  = !draining_any && (st_q[rp_q] == ST_READY);
  assign do_retire = rd_done && draining_any;
  assign err_set   = (wr_eop && (!filling_any || len_over)) || (rd_done && !draining_any) || do_tmo;

`ifdef TX_WATCHDOG_EN
  // Fires on the edge where the count would reach 2^TMO_NBIT-1 DRAINING cycles.
  localparam logic [TMO_NBIT-1:0] TMO_LAST = {{(TMO_NBIT-1){1'b1}}, 1'b0};
  logic [TMO_NBIT-1:0] wdog_q;

  assign do_tmo = draining_any && !rd_done && (wdog_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else if (!draining_any || do_tmo) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + TMO_NBIT'(1);
    end
  end
`else
  assign do_tmo = 1'b0;
`endif

  // An empty fill hands the bank back, so wp is restored and in-order draining holds.
  assign wp_d = wp_q ^ do_grant ^ (do_fill && fill_empty);
  assign rp_d = rp_q ^ (do_retire || do_tmo);

  always_comb begin
    st_d = st_q;
    if (do_grant)              st_d[wp_q]      = ST_FILLING;
    if (do_fill)               st_d[fill_bank] = fill_empty ? ST_FREE : ST_READY;
    if (do_drain)              st_d[rp_q]      = ST_DRAINING;
    if (do_retire || do_tmo)   st_d[rd_bank_q] = ST_FREE;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_flags
    assign bank_rdy_d[gi] = (st_d[gi] == ST_READY) || (st_d[gi] == ST_DRAINING);
    assign busy_d[gi]     = (st_d[gi] != ST_FREE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= '{default: ST_FREE};
      len_q      <= '{default: '0};
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
      wr_gnt_q   <= 1'b0;
      wr_bank_q  <= 1'b0;
      rd_sop_q   <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_len_q   <= '0;
      bank_rdy_q <= 2'b00;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      st_q       <= st_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      wr_gnt_q   <= do_grant;
      rd_sop_q   <= do_drain;
      bank_rdy_q <= bank_rdy_d;
      busy_q     <= |busy_d;
      if (do_grant) wr_bank_q <= wp_q;
      if (do_fill)  len_q[fill_bank] <= len_clamp;
      if (do_drain) begin
        rd_bank_q <= rp_q;
        rd_len_q  <= len_q[rp_q];
      end
      if (err_set)  err_q <= 1'b1;
    end
  end

  assign wr_gnt   = wr_gnt_q;
  assign wr_bank  = wr_bank_q;
  assign rd_sop   = rd_sop_q;
  assign rd_bank  = rd_bank_q;
  assign rd_len   = rd_len_q;
  assign bank_rdy = bank_rdy_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule
